// File: rtl/fma_addend_aligner.sv
// fma_addend_aligner: front end of the FP32 fused multiply-add datapath.
// Unpacks A, B and C and computes the product exponent of A*B.
// Right-shifts C's significand into the 3*PARM_MANT+5 bit sum window and
// collects a sticky bit. Results go out through a 2-stage valid/ready pipeline.
// Optional feature macro: FMA_ALIGNER_SPECIAL_EN enables special-case
// classification on Special_o. Without it, Special_o is tied to 2'b00.
module fma_addend_aligner #(
    parameter int PARM_EXP  = 8,
    parameter int PARM_MANT = 23,
    parameter int PARM_BIAS = 127
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [PARM_EXP+PARM_MANT:0]   A_i,
    input  logic [PARM_EXP+PARM_MANT:0]   B_i,
    input  logic [PARM_EXP+PARM_MANT:0]   C_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [PARM_MANT:0]            Mant_a_o,
    output logic [PARM_MANT:0]            Mant_b_o,
    output logic [3*PARM_MANT+4:0]        Mant_align_o,
    output logic                          Sticky_o,
    output logic [PARM_EXP+1:0]           Exp_o,
    output logic                          Sign_prod_o,
    output logic                          Sub_o,
    output logic [1:0]                    Special_o
);

    localparam int OPW  = PARM_EXP + PARM_MANT + 1;
    localparam int SIGW = PARM_MANT + 1;
    localparam int WIN  = 3 * PARM_MANT + 5;
    localparam int PADW = 2 * PARM_MANT + 4;
    localparam int XW   = 12;
    localparam int SHW  = $clog2(WIN);

    localparam logic signed [XW-1:0] ALIGN_OFS = XW'(PARM_MANT + 3);
    localparam logic signed [XW-1:0] BIAS_S    = XW'(PARM_BIAS);
    localparam logic signed [XW-1:0] EXP_MAX   = XW'((1 << (PARM_EXP + 1)) - 1);
    localparam logic signed [XW-1:0] WIN_S     = XW'(WIN);

    // ------------------------------------------------------------------
    // Operand unpacking (combinational, feeds stage 1)
    // ------------------------------------------------------------------
    logic [PARM_EXP-1:0]    w_expA, w_expB, w_expC;
    logic [PARM_MANT-1:0]   w_fracA, w_fracB, w_fracC;
    logic                   w_hidA, w_hidB, w_hidC;
    logic [PARM_EXP-1:0]    w_effA, w_effB, w_effC;
    logic signed [XW-1:0]   w_ea, w_eb, w_ec, w_ep, w_sa;
    logic                   w_signProd, w_sub;
    logic [1:0]             w_special;

    assign w_expA  = A_i[OPW-2 -: PARM_EXP];
    assign w_expB  = B_i[OPW-2 -: PARM_EXP];
    assign w_expC  = C_i[OPW-2 -: PARM_EXP];
    assign w_fracA = A_i[PARM_MANT-1:0];
    assign w_fracB = B_i[PARM_MANT-1:0];
    assign w_fracC = C_i[PARM_MANT-1:0];

    // A zero exponent field marks a subnormal: no hidden bit, exponent 1
    assign w_hidA = |w_expA;
    assign w_hidB = |w_expB;
    assign w_hidC = |w_expC;
    assign w_effA = w_hidA ? w_expA : PARM_EXP'(1);
    assign w_effB = w_hidB ? w_expB : PARM_EXP'(1);
    assign w_effC = w_hidC ? w_expC : PARM_EXP'(1);

    assign w_ea = {{(XW-PARM_EXP){1'b0}}, w_effA};
    assign w_eb = {{(XW-PARM_EXP){1'b0}}, w_effB};
    assign w_ec = {{(XW-PARM_EXP){1'b0}}, w_effC};

    // Product exponent and the right-shift C needs to line up with the window
    assign w_ep = w_ea + w_eb - BIAS_S;
    assign w_sa = w_ep - w_ec + ALIGN_OFS;

    assign w_signProd = A_i[OPW-1] ^ B_i[OPW-1];
    assign w_sub      = w_signProd ^ C_i[OPW-1];

`ifdef FMA_ALIGNER_SPECIAL_EN
    logic w_zeroA, w_zeroB;
    logic w_infA, w_infB, w_infC;
    logic w_nanA, w_nanB, w_nanC;
    logic w_anyNan, w_anyInf;

    // Classify operands; NaN outranks infinity, which outranks a zero product
    always_comb begin
        w_zeroA   = ~|w_expA & ~|w_fracA;
        w_zeroB   = ~|w_expB & ~|w_fracB;
        w_infA    = (&w_expA) & ~|w_fracA;
        w_infB    = (&w_expB) & ~|w_fracB;
        w_infC    = (&w_expC) & ~|w_fracC;
        w_nanA    = (&w_expA) & (|w_fracA);
        w_nanB    = (&w_expB) & (|w_fracB);
        w_nanC    = (&w_expC) & (|w_fracC);
        w_anyNan  = w_nanA | w_nanB | w_nanC
                  | ((w_infA | w_infB) & (w_zeroA | w_zeroB))
                  | ((w_infA | w_infB) & w_infC & w_sub);
        w_anyInf  = w_infA | w_infB | w_infC;
        w_special = 2'b00;
        if (w_anyNan) begin
            w_special = 2'b11;
        end else if (w_anyInf) begin
            w_special = 2'b10;
        end else if (w_zeroA | w_zeroB) begin
            w_special = 2'b01;
        end
    end
`else
    assign w_special = 2'b00;
`endif

    // ------------------------------------------------------------------
    // Handshake: each stage loads when empty or when it drains this cycle
    // ------------------------------------------------------------------
    logic r_s1Valid, r_s2Valid;
    logic w_s1Ready, w_s2Ready;

    assign w_s2Ready = ~r_s2Valid | ready_i;
    assign w_s1Ready = ~r_s1Valid | w_s2Ready;
    assign ready_o   = w_s1Ready;
    assign valid_o   = r_s2Valid;

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic [SIGW-1:0]        r_s1MantA, r_s1MantB, r_s1MantC;
    logic signed [XW-1:0]   r_s1Ec, r_s1Ep, r_s1Sa;
    logic                   r_s1SignProd, r_s1Sub;
    logic [1:0]             r_s1Special;

    // Stage 1 captures unpacked operands and exponent arithmetic on acceptance
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1Valid    <= 1'b0;
            r_s1MantA    <= '0;
            r_s1MantB    <= '0;
            r_s1MantC    <= '0;
            r_s1Ec       <= '0;
            r_s1Ep       <= '0;
            r_s1Sa       <= '0;
            r_s1SignProd <= 1'b0;
            r_s1Sub      <= 1'b0;
            r_s1Special  <= 2'b00;
        end else if (w_s1Ready) begin
            r_s1Valid <= valid_i;
            if (valid_i) begin
                r_s1MantA    <= {w_hidA, w_fracA};
                r_s1MantB    <= {w_hidB, w_fracB};
                r_s1MantC    <= {w_hidC, w_fracC};
                r_s1Ec       <= w_ec;
                r_s1Ep       <= w_ep;
                r_s1Sa       <= w_sa;
                r_s1SignProd <= w_signProd;
                r_s1Sub      <= w_sub;
                r_s1Special  <= w_special;
            end
        end
    end

    // ------------------------------------------------------------------
    // Alignment shifter (combinational, feeds stage 2)
    // ------------------------------------------------------------------
    logic [WIN-1:0]         w_full, w_alignMant;
    logic [SHW-1:0]         w_shamt;
    logic                   w_alignSticky;
    logic signed [XW-1:0]   w_alignExp;
    logic                   w_expOvf;

    // Shift C right by sa; once sa > 0, Ec + sa is simply Ep + PARM_MANT + 3
    always_comb begin
        w_full        = {r_s1MantC, {PADW{1'b0}}};
        w_shamt       = r_s1Sa[SHW-1:0];
        w_alignMant   = '0;
        w_alignSticky = 1'b0;
        w_alignExp    = r_s1Ec;
        if (r_s1Sa <= 0) begin
            w_alignMant = w_full;
        end else if (r_s1Sa < WIN_S) begin
            w_alignMant   = w_full >> w_shamt;
            w_alignSticky = |(w_full & ~({WIN{1'b1}} << w_shamt));
            w_alignExp    = r_s1Ep + ALIGN_OFS;
        end else begin
            w_alignSticky = |r_s1MantC;
            w_alignExp    = r_s1Ep + ALIGN_OFS;
        end
        w_expOvf = (w_alignExp < 0) || (w_alignExp > EXP_MAX);
    end

    // ------------------------------------------------------------------
    // Stage 2 registers (drive the outputs directly, so they hold on stall)
    // ------------------------------------------------------------------
    logic [SIGW-1:0]        r_s2MantA, r_s2MantB;
    logic [WIN-1:0]         r_s2Mant;
    logic                   r_s2Sticky;
    logic [PARM_EXP+1:0]    r_s2Exp;
    logic                   r_s2SignProd, r_s2Sub;
    logic [1:0]             r_s2Special;

    // Stage 2 takes the aligned result whenever stage 1 advances
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s2Valid    <= 1'b0;
            r_s2MantA    <= '0;
            r_s2MantB    <= '0;
            r_s2Mant     <= '0;
            r_s2Sticky   <= 1'b0;
            r_s2Exp      <= '0;
            r_s2SignProd <= 1'b0;
            r_s2Sub      <= 1'b0;
            r_s2Special  <= 2'b00;
        end else if (w_s2Ready) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_s2MantA    <= r_s1MantA;
                r_s2MantB    <= r_s1MantB;
                r_s2Mant     <= w_alignMant;
                r_s2Sticky   <= w_alignSticky;
                r_s2Exp      <= {w_expOvf, w_alignExp[PARM_EXP:0]};
                r_s2SignProd <= r_s1SignProd;
                r_s2Sub      <= r_s1Sub;
                r_s2Special  <= r_s1Special;
            end
        end
    end

    assign Mant_a_o     = r_s2MantA;
    assign Mant_b_o     = r_s2MantB;
    assign Mant_align_o = r_s2Mant;
    assign Sticky_o     = r_s2Sticky;
    assign Exp_o        = r_s2Exp;
    assign Sign_prod_o  = r_s2SignProd;
    assign Sub_o        = r_s2Sub;
    assign Special_o    = r_s2Special;

endmodule

// File: tb/tb_fma_addend_aligner.sv
// tb_fma_addend_aligner: randomized and directed checks of fma_addend_aligner
// against a behavioural model of the alignment rules and pipeline timing.
// Honors FMA_ALIGNER_SPECIAL_EN the same way as the design.
module tb_fma_addend_aligner;

    localparam int WIN = 74;

`ifdef FMA_ALIGNER_SPECIAL_EN
    localparam logic [1:0] SPECIAL_INF_ZERO = 2'b11;
`else
    localparam logic [1:0] SPECIAL_INF_ZERO = 2'b00;
`endif

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            valid_i = 1'b0;
    logic            ready_o;
    logic [31:0]     A_i = '0;
    logic [31:0]     B_i = '0;
    logic [31:0]     C_i = '0;
    logic            valid_o;
    logic            ready_i = 1'b1;
    logic [23:0]     Mant_a_o, Mant_b_o;
    logic [WIN-1:0]  Mant_align_o;
    logic            Sticky_o;
    logic [9:0]      Exp_o;
    logic            Sign_prod_o, Sub_o;
    logic [1:0]      Special_o;

    fma_addend_aligner dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .A_i          (A_i),
        .B_i          (B_i),
        .C_i          (C_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .Mant_a_o     (Mant_a_o),
        .Mant_b_o     (Mant_b_o),
        .Mant_align_o (Mant_align_o),
        .Sticky_o     (Sticky_o),
        .Exp_o        (Exp_o),
        .Sign_prod_o  (Sign_prod_o),
        .Sub_o        (Sub_o),
        .Special_o    (Special_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [23:0]    mantA;
        logic [23:0]    mantB;
        logic [WIN-1:0] mant;
        logic           sticky;
        logic [9:0]     expo;
        logic           signProd;
        logic           sub;
        logic [1:0]     special;
        int             acceptEdge;
    } refItem_t;

    refItem_t   refQ[$];
    int         compareCount = 0;
    int         failCount = 0;
    int         edgeCount = 0;
    int         drainCount = 0;

    logic           sValid, sReady, sSticky, sSignProd, sSub;
    logic [23:0]    sMantA, sMantB;
    logic [WIN-1:0] sMant;
    logic [9:0]     sExp;
    logic [1:0]     sSpecial;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", tag, observed, expected);
        end
    endtask

    // Reference model: FP32 alignment rules written with plain integers
    function automatic refItem_t refModel(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c);
        refItem_t       r;
        int             ea, eb, ec, ep, sa, ev;
        logic [23:0]    mc;
        logic [WIN-1:0] full;
        logic           zA, zB, infA, infB, infC, nanA, nanB, nanC, nan;
        ea = (a[30:23] == 0) ? 1 : int'(a[30:23]);
        eb = (b[30:23] == 0) ? 1 : int'(b[30:23]);
        ec = (c[30:23] == 0) ? 1 : int'(c[30:23]);
        r.mantA = {a[30:23] != 0, a[22:0]};
        r.mantB = {b[30:23] != 0, b[22:0]};
        mc      = {c[30:23] != 0, c[22:0]};
        ep = ea + eb - 127;
        sa = ep - ec + 26;
        full = {mc, 50'd0};
        r.mant = '0;
        r.sticky = 1'b0;
        if (sa <= 0) begin
            r.mant = full;
            ev = ec;
        end else if (sa < WIN) begin
            for (int i = 0; i < WIN; i++) begin
                if (i >= sa) r.mant[i-sa] = full[i];
                else         r.sticky = r.sticky | full[i];
            end
            ev = ec + sa;
        end else begin
            r.sticky = |mc;
            ev = ep + 26;
        end
        r.expo[8:0] = ev[8:0];
        r.expo[9]   = (ev < 0) || (ev > 511);
        r.signProd  = a[31] ^ b[31];
        r.sub       = r.signProd ^ c[31];
        r.special   = 2'b00;
`ifdef FMA_ALIGNER_SPECIAL_EN
        zA   = (a[30:0] == 0);
        zB   = (b[30:0] == 0);
        infA = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        infB = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        infC = (c[30:23] == 8'hFF) && (c[22:0] == 0);
        nanA = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nanB = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        nanC = (c[30:23] == 8'hFF) && (c[22:0] != 0);
        nan  = nanA || nanB || nanC || ((infA || infB) && (zA || zB))
            || ((infA || infB) && infC && r.sub);
        if (nan)                      r.special = 2'b11;
        else if (infA || infB || infC) r.special = 2'b10;
        else if (zA || zB)            r.special = 2'b01;
`else
        zA = 1'b0; zB = 1'b0; infA = 1'b0; infB = 1'b0; infC = 1'b0;
        nanA = 1'b0; nanB = 1'b0; nanC = 1'b0; nan = 1'b0;
`endif
        r.acceptEdge = 0;
        return r;
    endfunction

    function automatic logic [31:0] randOperand();
        logic [31:0] v;
        int          kind;
        v = $urandom;
        kind = $urandom_range(0, 11);
        case (kind)
            0:       v[30:0] = '0;
            1:       begin v[30:23] = 8'hFF; v[22:0] = '0; end
            2:       v[30:23] = 8'hFF;
            3:       v[30:23] = 8'h00;
            4, 5:    ;
            default: v[30:23] = 8'(80 + $urandom_range(0, 95));
        endcase
        return v;
    endfunction

    // One clock: check outputs at the falling edge, update the model at the rising edge
    task automatic stepCycle(output bit accepted);
        bit acc, drain, expValid;
        @(negedge clk_i);
        expValid = (refQ.size() > 0) && (edgeCount >= refQ[0].acceptEdge + 1);
        checkOutput("readyO", 128'(ready_o), 128'(!((refQ.size() == 2) && !ready_i)));
        checkOutput("validO", 128'(valid_o), 128'(expValid));
        if (valid_o && expValid) begin
            checkOutput("mantA",     128'(Mant_a_o),     128'(refQ[0].mantA));
            checkOutput("mantB",     128'(Mant_b_o),     128'(refQ[0].mantB));
            checkOutput("mantAlign", 128'(Mant_align_o), 128'(refQ[0].mant));
            checkOutput("sticky",    128'(Sticky_o),     128'(refQ[0].sticky));
            checkOutput("exp",       128'(Exp_o),        128'(refQ[0].expo));
            checkOutput("signProd",  128'(Sign_prod_o),  128'(refQ[0].signProd));
            checkOutput("sub",       128'(Sub_o),        128'(refQ[0].sub));
            checkOutput("special",   128'(Special_o),    128'(refQ[0].special));
        end
        sValid = valid_o; sReady = ready_o; sMantA = Mant_a_o; sMantB = Mant_b_o;
        sMant = Mant_align_o; sSticky = Sticky_o; sExp = Exp_o;
        sSignProd = Sign_prod_o; sSub = Sub_o; sSpecial = Special_o;
        acc   = valid_i && ready_o;
        drain = valid_o && ready_i;
        @(posedge clk_i);
        edgeCount++;
        if (rst_i) begin
            refQ.delete();
        end else begin
            if (drain && refQ.size() > 0) begin
                void'(refQ.pop_front());
                drainCount++;
            end
            if (acc) begin
                refItem_t item;
                item = refModel(A_i, B_i, C_i);
                item.acceptEdge = edgeCount;
                refQ.push_back(item);
            end
        end
        accepted = acc && !rst_i;
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c);
        bit acc;
        int tries;
        A_i = a; B_i = b; C_i = c; valid_i = 1'b1;
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 20) begin
            stepCycle(acc);
            tries++;
        end
        if (!acc) checkOutput("acceptTimeout", 128'(0), 128'(1));
        valid_i = 1'b0;
    endtask

    task automatic runDirected(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input logic [9:0] eExp,
                               input logic [WIN-1:0] eMant, input logic eSticky,
                               input logic eSub, input logic [1:0] eSpecial);
        bit acc;
        int lat;
        ready_i = 1'b1;
        applyStimulus(a, b, c);
        lat = 0;
        do begin
            stepCycle(acc);
            lat++;
        end while (!sValid && lat < 10);
        checkOutput({tag, "Latency"}, 128'(lat),     128'(2));
        checkOutput({tag, "Exp"},     128'(sExp),    128'(eExp));
        checkOutput({tag, "Mant"},    128'(sMant),   128'(eMant));
        checkOutput({tag, "Sticky"},  128'(sSticky), 128'(eSticky));
        checkOutput({tag, "Sub"},     128'(sSub),    128'(eSub));
        checkOutput({tag, "Special"}, 128'(sSpecial), 128'(eSpecial));
    endtask

    // Stall scenario operands
    logic [31:0] stallA [4] = '{32'h3F800000, 32'h40000000, 32'h3FC00000, 32'hC0400000};
    logic [31:0] stallB [4] = '{32'h3F800000, 32'h3F000000, 32'h41200000, 32'h3F800000};
    logic [31:0] stallC [4] = '{32'h40800000, 32'h3E800000, 32'hC2C80000, 32'h4B000001};

    initial begin
        bit acc;
        int idx, stallLeft, startDrain;
        bit sawFirst, sawReadyLow;

        // Reset and check the idle state
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("rstValid", 128'(valid_o),      128'(0));
        checkOutput("rstReady", 128'(ready_o),      128'(1));
        checkOutput("rstMant",  128'(Mant_align_o), 128'(0));
        checkOutput("rstExp",   128'(Exp_o),        128'(0));
        checkOutput("rstMantA", 128'(Mant_a_o),     128'(0));
        @(posedge clk_i);
        #1;

        // Directed alignment cases
        runDirected("unity", 32'h3F800000, 32'h3F800000, 32'h3F800000,
                    10'd153, 74'd1 << 47, 1'b0, 1'b0, 2'b00);
        runDirected("bigC", 32'h3F800000, 32'h3F800000, 32'h53800000,
                    10'd167, 74'd1 << 73, 1'b0, 1'b0, 2'b00);
        runDirected("tinyC", 32'h3F800000, 32'h3F800000, 32'h0D800000,
                    10'd153, 74'd0, 1'b1, 1'b0, 2'b00);
        runDirected("infZero", 32'h7F800000, 32'h00000000, 32'h3F800000,
                    10'd155, 74'd1 << 45, 1'b0, 1'b0, SPECIAL_INF_ZERO);

        // Back-to-back stream with a 3-cycle downstream stall
        idx = 0; stallLeft = 0; sawFirst = 1'b0; sawReadyLow = 1'b0;
        startDrain = drainCount;
        for (int cyc = 0; cyc < 40 && (drainCount - startDrain) < 4; cyc++) begin
            if (idx < 4) begin
                valid_i = 1'b1; A_i = stallA[idx]; B_i = stallB[idx]; C_i = stallC[idx];
            end else begin
                valid_i = 1'b0;
            end
            ready_i = (stallLeft > 0) ? 1'b0 : 1'b1;
            stepCycle(acc);
            if (acc) idx++;
            if (!sReady) sawReadyLow = 1'b1;
            if (stallLeft > 0) stallLeft--;
            else if (sValid && !sawFirst) begin
                sawFirst = 1'b1;
                stallLeft = 3;
            end
        end
        valid_i = 1'b0;
        checkOutput("stallDrained",   128'(drainCount - startDrain), 128'(4));
        checkOutput("stallReadyDrop", 128'(sawReadyLow),             128'(1));

        // Reset with two transactions in flight
        ready_i = 1'b1;
        applyStimulus(randOperand(), randOperand(), randOperand());
        applyStimulus(randOperand(), randOperand(), randOperand());
        rst_i = 1'b1;
        stepCycle(acc);
        rst_i = 1'b0;
        stepCycle(acc);
        checkOutput("midRstValid",  128'(sValid),  128'(0));
        checkOutput("midRstMant",   128'(sMant),   128'(0));
        checkOutput("midRstExp",    128'(sExp),    128'(0));
        checkOutput("midRstSticky", 128'(sSticky), 128'(0));
        checkOutput("midRstMantB",  128'(sMantB),  128'(0));
        repeat (4) stepCycle(acc);

        // Randomized traffic with random backpressure
        for (int cyc = 0; cyc < 600; cyc++) begin
            valid_i = ($urandom_range(0, 9) < 7);
            ready_i = ($urandom_range(0, 9) < 7);
            A_i = randOperand(); B_i = randOperand(); C_i = randOperand();
            stepCycle(acc);
        end

        // Drain whatever is still in flight
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int cyc = 0; cyc < 10 && refQ.size() > 0; cyc++) stepCycle(acc);
        checkOutput("finalDrain", 128'(refQ.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, wanted completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

endmodule
